// File: rtl/ch_frame_buffer_pkg.sv
// Shared types and constants for the per-channel store-and-forward frame buffer.
// Covers the data width, the frame descriptor layout and the read-FSM encoding.
package ch_frame_buffer_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned START_W    = 11;   // matches the default buffer address width
    localparam int unsigned LEN_W      = 11;
    localparam int unsigned GAP_CYCLES = 2;

    typedef struct packed {
        logic [START_W-1:0] start;
        logic [LEN_W-1:0]   len;
        logic               err;
    } desc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_GAP
    } rd_state_e;

endpackage

// File: rtl/sdp_ram_1clk.sv
// Simple dual-port byte RAM: one write port, one read port, single clock,
// registered read data (1-cycle latency).
module sdp_ram_1clk
    import ch_frame_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ch_frame_buffer.sv
// Store-and-forward frame buffer feeding one channel of the round-robin send arbiter:
// stores complete frames, requests, then streams a granted frame gap-free.
module ch_frame_buffer
    import ch_frame_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned DESC_AW = 3,
    parameter int unsigned MAX_LEN = 1500
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic               in_error,
    output logic [DATA_W-1:0]  ch_data,
    output logic               ch_datavalid,
    output logic               ch_error,
    output logic               ch_request,
    output logic               ch_last,
    input  logic               ch_grant,
    output logic [DESC_AW:0]   frames_pending,
    output logic               drop_pulse
);

    localparam logic [ADDR_W:0]    DEPTH      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LEN_W-1:0]   MAX_LEN_L  = LEN_W'(MAX_LEN);
    localparam logic [DESC_AW:0]   DESC_DEPTH = {1'b1, {DESC_AW{1'b0}}};

    // write side
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   frame_start_q, frame_start_d;
    logic [LEN_W-1:0]  frame_len_q, frame_len_d;
    logic              frame_err_q, frame_err_d;
    logic              dropping_q, dropping_d;
    logic              drop_pulse_q, drop_pulse_d;
    logic [ADDR_W:0]   rd_base_q, rd_base_d;
    logic [ADDR_W:0]   used;
    logic              drop_now;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] ram_raddr;

    // descriptor FIFO
    desc_t             desc_mem_q [2**DESC_AW];
    logic [DESC_AW:0]  dwr_q, dwr_d, drd_q, drd_d;
    logic [DESC_AW:0]  desc_count;
    logic              desc_full, desc_empty;
    logic              push, pop;
    desc_t             push_desc, head;

    // read side
    rd_state_e         state_q, state_d;
    logic [1:0]        gap_cnt_q, gap_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  issue_left_q, issue_left_d;
    logic [LEN_W-1:0]  cur_len_q, cur_len_d;
    logic              cur_err_q, cur_err_d;
    logic              issue, issue_last;
    logic              ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
    logic [DATA_W-1:0] ch_data_q, ch_data_d;
    logic              ch_datavalid_q, ch_datavalid_d;
    logic              ch_error_q, ch_error_d;
    logic              ch_last_q, ch_last_d;
    logic              ch_request_q, ch_request_d;

    assign used       = wr_ptr_q - rd_base_q;
    assign desc_count = dwr_q - drd_q;
    assign desc_full  = (desc_count == DESC_DEPTH);
    assign desc_empty = (desc_count == '0);
    assign head       = desc_mem_q[drd_q[DESC_AW-1:0]];

    sdp_ram_1clk #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (in_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        frame_start_d = frame_start_q;
        frame_len_d   = frame_len_q;
        frame_err_d   = frame_err_q;
        dropping_d    = dropping_q;
        drop_pulse_d  = 1'b0;
        drop_now      = 1'b0;
        ram_we        = 1'b0;
        push          = 1'b0;
        push_desc     = '0;
        if (in_valid) begin
            drop_now = dropping_q || (used == DEPTH) || (frame_len_q >= MAX_LEN_L);
            if (!drop_now) begin
                ram_we      = 1'b1;
                wr_ptr_d    = wr_ptr_q + (ADDR_W+1)'(1);
                frame_len_d = frame_len_q + LEN_W'(1);
                frame_err_d = frame_err_q | in_error;
            end
            if (in_last) begin
                if (!drop_now && !desc_full) begin
                    push            = 1'b1;
                    push_desc.start = START_W'(frame_start_q[ADDR_W-1:0]);
                    push_desc.len   = frame_len_q + LEN_W'(1);
                    push_desc.err   = frame_err_q | in_error;
                    frame_start_d   = wr_ptr_q + (ADDR_W+1)'(1);
                end else begin
                    wr_ptr_d     = frame_start_q;
                    drop_pulse_d = 1'b1;
                end
                frame_len_d = '0;
                frame_err_d = 1'b0;
                dropping_d  = 1'b0;
            end else if (drop_now) begin
                // rewind now so the partial frame stops counting against used space
                dropping_d = 1'b1;
                wr_ptr_d   = frame_start_q;
            end
        end
        dwr_d = push ? dwr_q + (DESC_AW+1)'(1) : dwr_q;
        drd_d = pop  ? drd_q + (DESC_AW+1)'(1) : drd_q;
    end

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        rd_addr_d    = rd_addr_q;
        issue_left_d = issue_left_q;
        cur_len_d    = cur_len_q;
        cur_err_d    = cur_err_q;
        rd_base_d    = rd_base_q;
        ram_raddr    = rd_addr_q;
        pop          = 1'b0;
        issue        = 1'b0;
        issue_last   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!desc_empty) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ch_grant) begin
                    // first read goes out in the grant cycle so data appears at grant+2
                    pop          = 1'b1;
                    issue        = 1'b1;
                    issue_last   = (head.len == LEN_W'(1));
                    ram_raddr    = ADDR_W'(head.start);
                    rd_addr_d    = ADDR_W'(head.start) + ADDR_W'(1);
                    issue_left_d = head.len - LEN_W'(1);
                    cur_len_d    = head.len;
                    cur_err_d    = head.err;
                    state_d      = ST_RD;
                end
            end
            ST_RD: begin
                if (issue_left_q != '0) begin
                    issue        = 1'b1;
                    issue_last   = (issue_left_q == LEN_W'(1));
                    rd_addr_d    = rd_addr_q + ADDR_W'(1);
                    issue_left_d = issue_left_q - LEN_W'(1);
                end
                if (ch_last_q) begin
                    rd_base_d = rd_base_q + (ADDR_W+1)'(cur_len_q);
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 2'd1;
                if (gap_cnt_q == 2'(GAP_CYCLES - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ch_request_d   = (state_d == ST_REQ);
        ram_vld_d      = issue;
        ram_last_d     = issue_last;
        ch_datavalid_d = ram_vld_q;
        ch_data_d      = ram_vld_q ? ram_rdata : '0;
        ch_last_d      = ram_last_q;
        ch_error_d     = ram_vld_q & cur_err_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            desc_mem_q[dwr_q[DESC_AW-1:0]] <= push_desc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            frame_start_q  <= '0;
            frame_len_q    <= '0;
            frame_err_q    <= 1'b0;
            dropping_q     <= 1'b0;
            drop_pulse_q   <= 1'b0;
            rd_base_q      <= '0;
            dwr_q          <= '0;
            drd_q          <= '0;
            state_q        <= ST_IDLE;
            gap_cnt_q      <= '0;
            rd_addr_q      <= '0;
            issue_left_q   <= '0;
            cur_len_q      <= '0;
            cur_err_q      <= 1'b0;
            ram_vld_q      <= 1'b0;
            ram_last_q     <= 1'b0;
            ch_data_q      <= '0;
            ch_datavalid_q <= 1'b0;
            ch_error_q     <= 1'b0;
            ch_last_q      <= 1'b0;
            ch_request_q   <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            frame_start_q  <= frame_start_d;
            frame_len_q    <= frame_len_d;
            frame_err_q    <= frame_err_d;
            dropping_q     <= dropping_d;
            drop_pulse_q   <= drop_pulse_d;
            rd_base_q      <= rd_base_d;
            dwr_q          <= dwr_d;
            drd_q          <= drd_d;
            state_q        <= state_d;
            gap_cnt_q      <= gap_cnt_d;
            rd_addr_q      <= rd_addr_d;
            issue_left_q   <= issue_left_d;
            cur_len_q      <= cur_len_d;
            cur_err_q      <= cur_err_d;
            ram_vld_q      <= ram_vld_d;
            ram_last_q     <= ram_last_d;
            ch_data_q      <= ch_data_d;
            ch_datavalid_q <= ch_datavalid_d;
            ch_error_q     <= ch_error_d;
            ch_last_q      <= ch_last_d;
            ch_request_q   <= ch_request_d;
        end
    end

    assign ch_data        = ch_data_q;
    assign ch_datavalid   = ch_datavalid_q;
    assign ch_error       = ch_error_q;
    assign ch_last        = ch_last_q;
    assign ch_request     = ch_request_q;
    assign frames_pending = desc_count;
    assign drop_pulse     = drop_pulse_q;

endmodule

// File: doc/ch_frame_buffer.md
Name: ch_frame_buffer

Overview:
- Per-channel store-and-forward frame buffer; one instance sits directly upstream of each channel port (ch0..ch3) of the 4-channel round-robin Ethernet send arbiter.
- Accepts a byte stream with end-of-frame markers from the acquisition/processing path and holds complete frames in block RAM.
- Raises request once a complete frame is stored, then streams that frame gap-free after a one-cycle grant pulse, with last on the final byte.

Parameters:
- ADDR_W, 11, data RAM address width; buffer depth = 2**ADDR_W bytes.
- DESC_AW, 3, descriptor FIFO address width; holds 2**DESC_AW frames.
- MAX_LEN, 1500, maximum frame length in bytes; longer frames are dropped.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- in_data  in  8  upstream byte
- in_valid  in  1  in_data valid this cycle
- in_last  in  1  with in_valid: final byte of the frame
- in_error  in  1  with in_valid: frame is corrupt; sticky until in_last
- ch_data  out  8  byte to arbiter
- ch_datavalid  out  1  ch_data valid
- ch_error  out  1  frame error flag to arbiter
- ch_request  out  1  complete frame available
- ch_last  out  1  final byte of frame, coincident with its datavalid
- ch_grant  in  1  one-cycle grant pulse from arbiter
- frames_pending  out  DESC_AW+1  stored complete frames
- drop_pulse  out  1  one-cycle pulse per dropped frame

Behaviour:
- Reset: every output is 0; pointers, counters and FIFOs are cleared; any partial frame is discarded. Reset mid-readout stops the frame immediately, with no last.
- Write side: wr_ptr advances on each accepted byte; frame_start holds the frame's start address.
  - On in_valid&in_last: if the frame is not in drop state and the descriptor FIFO is not full, push descriptor {start, len, err} and commit wr_ptr. Otherwise rewind wr_ptr to frame_start and pulse drop_pulse.
  - Drop triggers: RAM full (used == 2**ADDR_W), len would exceed MAX_LEN, or descriptor FIFO full at in_last. Once dropping, all remaining bytes are discarded up to and including in_last, and wr_ptr is rewound. drop_pulse fires once per frame, on the in_last cycle.
- Used count = wr_ptr - rd_base, with ADDR_W+1-bit wrap arithmetic. Space freed by readout is released at ch_last.
- Read FSM:
  - IDLE: when the descriptor FIFO is non-empty, go to REQ.
  - REQ: ch_request=1. On ch_grant, set ch_request=0 (registered, next cycle), pop the descriptor and go to RD.
  - RD: issue one RAM read per cycle for len cycles; RAM read latency is 1 cycle; output registers are loaded from RAM. First ch_datavalid is asserted exactly 2 cycles after the cycle ch_grant is sampled high. ch_datavalid stays high for len consecutive cycles with no gaps. ch_last=1 on byte len only. ch_error = descriptor err, held for all bytes of that frame. Then go to GAP.
  - GAP: 2 cycles with ch_request=0 and ch_datavalid/ch_data/ch_last/ch_error=0. The arbiter samples a registered copy of last, so re-request is only allowed after this. Then go to IDLE.
- ch_grant in IDLE, RD or GAP is ignored.
- Outside RD, ch_data is 0.
- Writes and reads to RAM in the same cycle are independent; the write side never overwrites bytes of an uncommitted read. This is guaranteed by the used/full check.
- Simultaneous descriptor push and pop in one cycle: frames_pending is unchanged.
- 1-byte frame: a single cycle with ch_datavalid=ch_last=1.

Decomposition:
- Shared package holds: data width constant 8, descriptor struct {start[ADDR_W-1:0], len[10:0], err}, read FSM state encoding (IDLE, REQ, RD, GAP), and GAP_CYCLES=2.
- One sub-module, sdp_ram_1clk: simple dual-port RAM, 8-bit, 2**ADDR_W deep, 1-cycle registered read.
- The descriptor FIFO is inline: small register array with pointers.

Test Plan:
- Write a 64-byte frame (0x00..0x3F); grant 5 cycles after request. Expect ch_request to drop 1 cycle after grant, ch_datavalid from grant+2 for 64 contiguous cycles, data 0x00..0x3F, ch_last on 0x3F, ch_error=0.
- Write a 10-byte frame with in_error on byte 3. Expect ch_error=1 on all 10 output bytes and ch_last on byte 10.
- Write a 1600-byte frame (> MAX_LEN), then a 20-byte frame. Expect one drop_pulse, frames_pending=1, and only the 20-byte frame emitted.
- Write 9 back-to-back 4-byte frames with no grant (DESC_AW=3). Expect frames_pending=8 and a drop_pulse on the 9th in_last. Granting 8 times yields 8 intact frames in order.
- Issue grant pulses in IDLE and during RD. Expect no state change, output unchanged, and request reasserted no earlier than 2 cycles after ch_last.
- Assert rst_n=0 mid-readout (byte 30 of 64). Expect all outputs 0 next cycle, frames_pending=0, and no ch_last emitted.
